// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter.
// Holds the FSM state encoding, the requester-ID constants and the default
// address/data widths used by mem_arbiter and mem_arb_rr.
package mem_arbiter_pkg;

    localparam int unsigned DefAw = 4;
    localparam int unsigned DefDw = 8;

    // Requester identifiers; also the encoding of the last-grant register.
    localparam logic ReqIdA = 1'b0;
    localparam logic ReqIdB = 1'b1;

    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StAccess = 2'b01,
        StDone   = 2'b10
    } arb_state_e;

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin grant logic (combinational).
// Ports:
//   req_a, req_b : requests from requester A and B
//   last_gnt     : ID of the requester granted most recently
//   gnt_valid    : at least one request present
//   gnt_id       : ID of the requester to grant
module mem_arb_rr
    import mem_arbiter_pkg::*;
(
    input  logic req_a,
    input  logic req_b,
    input  logic last_gnt,
    output logic gnt_valid,
    output logic gnt_id
);

    always_comb begin
        gnt_valid = req_a | req_b;
        gnt_id    = ReqIdA;
        if (req_a && req_b) begin
            // Tie: favour whichever side did not win last time.
            gnt_id = (last_gnt == ReqIdA) ? ReqIdB : ReqIdA;
        end else if (req_b) begin
            gnt_id = ReqIdB;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates two requesters (A, B) onto a single-port memory.
// Each access runs IDLE -> ACCESS -> DONE: the winner's command is latched on
// the grant edge, the memory strobe fires in ACCESS, and ACK plus captured
// read data are presented in DONE.
// Ports:
//   CLK, RST_N                          : clock, synchronous active-low reset
//   REQ_x, WE_x, ADDR_x, WDATA_x        : request, write enable, address, data
//   ACK_x, RDATA_x                      : completion pulse, registered read data
//   MEM_READ, MEM_WRITE                 : memory strobes
//   MEM_AR, MEM_INDATA, MEM_OUTDATA     : memory address, write data, read data
//   BUSY                                : high outside IDLE
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned AW = DefAw,
    parameter int unsigned DW = DefDw
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          REQ_A,
    input  logic          WE_A,
    input  logic [AW-1:0] ADDR_A,
    input  logic [DW-1:0] WDATA_A,
    output logic          ACK_A,
    output logic [DW-1:0] RDATA_A,
    input  logic          REQ_B,
    input  logic          WE_B,
    input  logic [AW-1:0] ADDR_B,
    input  logic [DW-1:0] WDATA_B,
    output logic          ACK_B,
    output logic [DW-1:0] RDATA_B,
    output logic          MEM_READ,
    output logic          MEM_WRITE,
    output logic [AW-1:0] MEM_AR,
    output logic [DW-1:0] MEM_INDATA,
    input  logic [DW-1:0] MEM_OUTDATA,
    output logic          BUSY
);

    arb_state_e    state_q, state_d;
    logic          gnt_valid;
    logic          gnt_id;
    // Doubles as the ID of the transaction in flight, since it updates on grant.
    logic          last_q;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] rdata_a_q;
    logic [DW-1:0] rdata_b_q;

    mem_arb_rr u_rr (
        .req_a     (REQ_A),
        .req_b     (REQ_B),
        .last_gnt  (last_q),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (gnt_valid) state_d = StAccess;
            StAccess: state_d = StDone;
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q   <= StIdle;
            last_q    <= ReqIdB;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_a_q <= '0;
            rdata_b_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && gnt_valid) begin
                last_q  <= gnt_id;
                we_q    <= (gnt_id == ReqIdA) ? WE_A : WE_B;
                addr_q  <= (gnt_id == ReqIdA) ? ADDR_A : ADDR_B;
                wdata_q <= (gnt_id == ReqIdA) ? WDATA_A : WDATA_B;
            end
            if (state_q == StAccess && !we_q) begin
                if (last_q == ReqIdA) begin
                    rdata_a_q <= MEM_OUTDATA;
                end else begin
                    rdata_b_q <= MEM_OUTDATA;
                end
            end
        end
    end

    always_comb begin
        MEM_READ   = (state_q == StAccess) && !we_q;
        MEM_WRITE  = (state_q == StAccess) && we_q;
        MEM_AR     = addr_q;
        MEM_INDATA = wdata_q;
        ACK_A      = (state_q == StDone) && (last_q == ReqIdA);
        ACK_B      = (state_q == StDone) && (last_q == ReqIdB);
        RDATA_A    = rdata_a_q;
        RDATA_B    = rdata_b_q;
        BUSY       = (state_q != StIdle);
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a small behavioural memory.
module tb_mem_arbiter;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic       REQ_A, WE_A, REQ_B, WE_B;
    logic [3:0] ADDR_A, ADDR_B;
    logic [7:0] WDATA_A, WDATA_B;
    logic       ACK_A, ACK_B, MEM_READ, MEM_WRITE, BUSY;
    logic [7:0] RDATA_A, RDATA_B, MEM_INDATA, MEM_OUTDATA;
    logic [3:0] MEM_AR;

    logic [7:0] mem [16];

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    mem_arbiter dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .REQ_A       (REQ_A),
        .WE_A        (WE_A),
        .ADDR_A      (ADDR_A),
        .WDATA_A     (WDATA_A),
        .ACK_A       (ACK_A),
        .RDATA_A     (RDATA_A),
        .REQ_B       (REQ_B),
        .WE_B        (WE_B),
        .ADDR_B      (ADDR_B),
        .WDATA_B     (WDATA_B),
        .ACK_B       (ACK_B),
        .RDATA_B     (RDATA_B),
        .MEM_READ    (MEM_READ),
        .MEM_WRITE   (MEM_WRITE),
        .MEM_AR      (MEM_AR),
        .MEM_INDATA  (MEM_INDATA),
        .MEM_OUTDATA (MEM_OUTDATA),
        .BUSY        (BUSY)
    );

    assign MEM_OUTDATA = mem[MEM_AR];

    always @(posedge CLK) begin
        if (MEM_WRITE) mem[MEM_AR] <= MEM_INDATA;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        mem[14] = 8'hB9;
        RST_N = 1'b0;
        REQ_A = 0; WE_A = 0; ADDR_A = 0; WDATA_A = 0;
        REQ_B = 0; WE_B = 0; ADDR_B = 0; WDATA_B = 0;
        tick();
        tick();
        chk("rst_busy", BUSY, 0);
        chk("rst_rd", MEM_READ, 0);
        chk("rst_wr", MEM_WRITE, 0);
        chk("rst_ar", MEM_AR, 0);
        chk("rst_indata", MEM_INDATA, 0);
        chk("rst_rdata_a", RDATA_A, 0);
        chk("rst_rdata_b", RDATA_B, 0);

        // Requests while reset is held must be ignored.
        REQ_A = 1; REQ_B = 1;
        tick();
        chk("rsthold_busy", BUSY, 0);
        chk("rsthold_ack", {ACK_A, ACK_B}, 0);
        chk("rsthold_strobe", {MEM_READ, MEM_WRITE}, 0);
        REQ_A = 0; REQ_B = 0;
        RST_N = 1'b1;
        tick();
        chk("idle_busy", BUSY, 0);

        // Write A: 5A -> [7]
        REQ_A = 1; WE_A = 1; ADDR_A = 4'h7; WDATA_A = 8'h5A;
        tick();
        chk("wa_acc_wr", MEM_WRITE, 1);
        chk("wa_acc_rd", MEM_READ, 0);
        chk("wa_acc_ar", MEM_AR, 4'h7);
        chk("wa_acc_indata", MEM_INDATA, 8'h5A);
        chk("wa_acc_busy", BUSY, 1);
        chk("wa_acc_ack", ACK_A, 0);
        tick();
        chk("wa_done_wr", MEM_WRITE, 0);
        chk("wa_done_ack_a", ACK_A, 1);
        chk("wa_done_ack_b", ACK_B, 0);
        chk("wa_done_ar", MEM_AR, 4'h7);
        chk("wa_done_busy", BUSY, 1);
        chk("wa_rdata_a", RDATA_A, 0);
        REQ_A = 0;
        tick();
        chk("wa_idle_ack", ACK_A, 0);
        chk("wa_idle_busy", BUSY, 0);
        chk("wa_idle_ar", MEM_AR, 4'h7);

        // Read A of [7]
        REQ_A = 1; WE_A = 0; ADDR_A = 4'h7;
        tick();
        chk("ra_acc_rd", MEM_READ, 1);
        chk("ra_acc_wr", MEM_WRITE, 0);
        tick();
        chk("ra_done_ack", ACK_A, 1);
        chk("ra_rdata_a", RDATA_A, 8'h5A);
        chk("ra_done_rd", MEM_READ, 0);
        REQ_A = 0;
        tick();

        // Read B of [E]
        REQ_B = 1; WE_B = 0; ADDR_B = 4'hE;
        tick();
        chk("rb_acc_rd", MEM_READ, 1);
        chk("rb_acc_ar", MEM_AR, 4'hE);
        tick();
        chk("rb_done_ack_b", ACK_B, 1);
        chk("rb_done_ack_a", ACK_A, 0);
        chk("rb_rdata_b", RDATA_B, 8'hB9);
        chk("rb_rdata_a_kept", RDATA_A, 8'h5A);
        REQ_B = 0;
        tick();

        // Write A to [3], reset sampled during ACCESS, then retried.
        REQ_A = 1; WE_A = 1; ADDR_A = 4'h3; WDATA_A = 8'h3C;
        tick();
        chk("ab_acc_wr", MEM_WRITE, 1);
        chk("ab_acc_ar", MEM_AR, 4'h3);
        RST_N = 1'b0;
        tick();
        chk("ab_busy", BUSY, 0);
        chk("ab_strobe", {MEM_READ, MEM_WRITE}, 0);
        chk("ab_ack", {ACK_A, ACK_B}, 0);
        chk("ab_ar", MEM_AR, 0);
        chk("ab_rdata_a", RDATA_A, 0);
        RST_N = 1'b1;
        tick();
        chk("ab_retry_wr", MEM_WRITE, 1);
        chk("ab_retry_ar", MEM_AR, 4'h3);
        chk("ab_retry_indata", MEM_INDATA, 8'h3C);
        tick();
        chk("ab_retry_ack", ACK_A, 1);
        REQ_A = 0;
        tick();

        // Tie from reset: A, B, A with both held continuously.
        RST_N = 1'b0;
        tick();
        RST_N = 1'b1;
        REQ_A = 1; WE_A = 0; ADDR_A = 4'h7;
        REQ_B = 1; WE_B = 0; ADDR_B = 4'hE;
        tick();
        chk("tie1_ar", MEM_AR, 4'h7);
        tick();
        chk("tie1_ack", {ACK_A, ACK_B}, 2'b10);
        chk("tie1_rdata_a", RDATA_A, 8'h5A);
        tick();
        chk("tie1_idle_ack", {ACK_A, ACK_B}, 2'b00);
        chk("tie1_idle_busy", BUSY, 0);
        tick();
        chk("tie2_ar", MEM_AR, 4'hE);
        chk("tie2_acc_ack", {ACK_A, ACK_B}, 2'b00);
        tick();
        chk("tie2_ack", {ACK_A, ACK_B}, 2'b01);
        chk("tie2_rdata_b", RDATA_B, 8'hB9);
        tick();
        tick();
        chk("tie3_ar", MEM_AR, 4'h7);
        tick();
        chk("tie3_ack", {ACK_A, ACK_B}, 2'b10);
        REQ_A = 0; REQ_B = 0;
        tick();

        // 20 idle cycles.
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("idle_busy_n", BUSY, 0);
            chk("idle_strobe_n", {MEM_READ, MEM_WRITE}, 0);
            chk("idle_ack_n", {ACK_A, ACK_B}, 0);
            chk("idle_ar_n", MEM_AR, 4'h7);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The parameters SHALL be as follows (name, default, meaning).
- AW, 4: memory address width.
- DW, 8: memory data width.

REQ-002 The ports SHALL be as follows (name, direction, width, meaning).
- CLK, input, 1: single system clock; all state updates on its rising edge.
- RST_N, input, 1: reset, synchronous, active-low.
- REQ_A, input, 1: access request from requester A (CPU).
- WE_A, input, 1: 1 = write, 0 = read, for requester A.
- ADDR_A, input, AW: address for requester A.
- WDATA_A, input, DW: write data for requester A.
- ACK_A, output, 1: one-cycle completion pulse to requester A.
- RDATA_A, output, DW: registered read data for requester A.
- REQ_B, WE_B, ADDR_B, WDATA_B, ACK_B, RDATA_B: identical set for requester B (I/O), with the same directions and widths.
- MEM_READ, output, 1: read strobe to the memory.
- MEM_WRITE, output, 1: write strobe to the memory.
- MEM_AR, output, AW: memory address.
- MEM_INDATA, output, DW: memory write data.
- MEM_OUTDATA, input, DW: memory read data (combinational from the memory).
- BUSY, output, 1: high in any state other than IDLE.

Function
REQ-003 The FSM SHALL have three states: IDLE, ACCESS and DONE.

REQ-004 The state transitions SHALL be as follows.
- IDLE to ACCESS: when REQ_A or REQ_B is sampled high.
- ACCESS to DONE: unconditionally.
- DONE to IDLE: unconditionally.

REQ-005 On the IDLE-to-ACCESS edge, the block SHALL latch the granted requester's WE, ADDR and WDATA into internal registers.
- MEM_AR, MEM_INDATA and the strobes SHALL be driven only from these registers, never combinationally from requester inputs.

REQ-006 During ACCESS, exactly one of MEM_READ or MEM_WRITE SHALL be high, selected by the latched WE, for exactly one cycle.
- Both strobes SHALL be low in IDLE and DONE.

REQ-007 MEM_AR and MEM_INDATA SHALL hold their latched values through ACCESS and DONE.
- They SHALL remain unchanged until the next grant, so the address is stable whenever MEM_WRITE is high.

REQ-008 Read data SHALL be captured on the clock edge ending ACCESS.
- MEM_OUTDATA is captured into RDATA of the granted requester.
- The other requester's RDATA is unchanged.
- Write cycles leave both RDATA registers unchanged.

REQ-009 The ACK of the granted requester SHALL be high for exactly the DONE cycle.
- Latency from REQ sampled in IDLE to ACK is 2 cycles.
- Throughput is one access per 3 cycles.

REQ-010 Requesters SHALL hold REQ, WE, ADDR and WDATA stable until ACK.
- REQ still high in the cycle after ACK SHALL be treated as a new request.

REQ-011 Arbitration SHALL be two-way round-robin.
- Single request: grant that requester.
- Both requesting: grant the requester not granted last.
- A last-grant register is updated on every grant.

REQ-012 The last-grant register SHALL reset to B, so that A wins the first tie.

REQ-013 Requests arriving in ACCESS or DONE SHALL be ignored until the next IDLE sample.
- No request SHALL be lost if it is held per REQ-010.

REQ-014 A request deasserted before the grant SHALL NOT be serviced.

REQ-015 ACK_A and ACK_B SHALL never be high in the same cycle.

REQ-016 BUSY SHALL be high in ACCESS and DONE and low in IDLE.

Reset
REQ-017 On the rising CLK edge where RST_N is sampled low, the block SHALL take the following reset values.
- State: IDLE.
- MEM_READ, MEM_WRITE, ACK_A, ACK_B, BUSY: 0.
- MEM_AR, MEM_INDATA, RDATA_A, RDATA_B: 0.
- Last-grant register: B.

REQ-018 A reset sampled during ACCESS or DONE SHALL abort the transaction.
- No ACK is issued.
- No strobe is driven in the following cycle.
- The aborted requester SHALL re-request.

REQ-019 While RST_N is held low, all outputs SHALL remain at their reset values regardless of REQ inputs.

Structure
REQ-020 A shared package SHALL hold the following.
- The state encoding: IDLE=2'b00, ACCESS=2'b01, DONE=2'b10.
- The requester-ID constants: A=0, B=1.
- The AW and DW defaults.

REQ-021 The round-robin grant logic SHALL be one sub-module, mem_arb_rr.
- Inputs: two requests and the last-grant bit.
- Outputs: a grant-valid flag and a grant ID.
- Combinational.

Verification
REQ-022 Write A: REQ_A=1, WE_A=1, ADDR_A=4'h7, WDATA_A=8'h5A.
- MEM_WRITE=1 with MEM_AR=7 and MEM_INDATA=5A for 1 cycle.
- ACK_A pulses 2 cycles after the request is sampled.
- A subsequent read of 7 returns 8'h5A.

REQ-023 Read B: REQ_B=1, WE_B=0, ADDR_B=4'hE, with memory[E]=8'hB9.
- MEM_READ=1 for 1 cycle.
- ACK_B pulses and RDATA_B=8'hB9.
- RDATA_A is unchanged.

REQ-024 Tie: REQ_A and REQ_B both raised from reset, each held until its ACK.
- Order of service is A, then B, then A, and so on.
- ACKs are 3 cycles apart, never simultaneous.

REQ-025 Reset mid-access: RST_N=0 sampled during ACCESS of a write to address 3.
- Next cycle: IDLE, all strobes 0, no ACK.
- After release with REQ held, the write completes normally.

REQ-026 Idle: no requests for 20 cycles.
- BUSY, MEM_READ, MEM_WRITE, ACK_A and ACK_B all stay 0.
- MEM_AR holds its last value.
